// File: rtl/sig_control_pkg.sv
// Shared types and constants for the highway/country-road signal controller.
package sig_control_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam int DEF_Y2RDELAY = 3;
  localparam int DEF_R2GDELAY = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sig_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module sig_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sig_control.sv
// Moore traffic-signal controller: highway green by default, country road
// served on sensor request through timed yellow and all-red phases.
module sig_control
  import sig_control_pkg::*;
#(
  parameter int Y2RDELAY = DEF_Y2RDELAY,
  parameter int R2GDELAY = DEF_R2GDELAY
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] hwy,
  output logic [1:0] cntry
);

  // A delay of 1 would give $clog2 == 0, so keep at least one bit.
  localparam int TW = (max_int(Y2RDELAY, R2GDELAY) > 1) ?
                      $clog2(max_int(Y2RDELAY, R2GDELAY)) : 1;
  localparam logic [TW-1:0] Y_LOAD = TW'(Y2RDELAY - 1);
  localparam logic [TW-1:0] R_LOAD = TW'(R2GDELAY - 1);

  state_t        state, next;
  logic          load;
  logic [TW-1:0] load_val;
  logic          zero;

  sig_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S0;
    end else begin
      state <= next;
    end
  end

  // Timer is loaded on the edge that enters a timed phase, so the phase
  // lasts exactly delay cycles and exits on the edge where the count is 0.
  always_comb begin
    next     = state;
    load     = 1'b0;
    load_val = '0;
    hwy      = GREEN;
    cntry    = RED;
    case (state)
      S0: begin
        if (X) begin
          next     = S1;
          load     = 1'b1;
          load_val = Y_LOAD;
        end
      end
      S1: begin
        hwy = YELLOW;
        if (zero) begin
          next     = S2;
          load     = 1'b1;
          load_val = R_LOAD;
        end
      end
      S2: begin
        hwy = RED;
        if (zero) next = S3;
      end
      S3: begin
        hwy   = RED;
        cntry = GREEN;
        if (!X) begin
          next     = S4;
          load     = 1'b1;
          load_val = Y_LOAD;
        end
      end
      S4: begin
        hwy   = RED;
        cntry = YELLOW;
        if (zero) next = S0;
      end
      default: next = S0;
    endcase
  end

endmodule

// File: tb/tb_sig_control.sv
// Directed bench for sig_control with default delays (yellow 3, all-red 2).
module tb_sig_control;

  logic       clock;
  logic       clear;
  logic       X;
  logic [1:0] hwy;
  logic [1:0] cntry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       x;
    logic [1:0] h;
    logic [1:0] c;
  } vec_t;

  vec_t vecs[$];

  sig_control dut (
    .clock (clock),
    .clear (clear),
    .X     (X),
    .hwy   (hwy),
    .cntry (cntry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [1:0] h_exp, input logic [1:0] c_exp);
    checks++;
    if (hwy !== h_exp || cntry !== c_exp) begin
      errors++;
      $display("FAIL %s t=%0t: hwy=%0d cntry=%0d, expected hwy=%0d cntry=%0d",
               name, $time, hwy, cntry, h_exp, c_exp);
    end
  endtask

  task automatic step(input logic x);
    X = x;
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input logic x, input logic [1:0] h, input logic [1:0] c);
    vec_t v;
    v.x = x;
    v.h = h;
    v.c = c;
    vecs.push_back(v);
  endfunction

  initial begin
    clear = 1'b1;
    X     = 1'b0;

    // Full cycle: X high for 15 edges then low.
    for (int i = 0; i < 3; i++) add(1'b1, 2'd1, 2'd0);
    for (int i = 0; i < 2; i++) add(1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 10; i++) add(1'b1, 2'd0, 2'd2);
    for (int i = 0; i < 3; i++) add(1'b0, 2'd0, 2'd1);
    add(1'b0, 2'd2, 2'd0);
    add(1'b0, 2'd2, 2'd0);
    // Short request: one-cycle pulse, S3 lasts one cycle.
    add(1'b1, 2'd1, 2'd0);
    add(1'b0, 2'd1, 2'd0);
    add(1'b0, 2'd1, 2'd0);
    add(1'b0, 2'd0, 2'd0);
    add(1'b0, 2'd0, 2'd0);
    add(1'b0, 2'd0, 2'd2);
    for (int i = 0; i < 3; i++) add(1'b0, 2'd0, 2'd1);
    add(1'b0, 2'd2, 2'd0);
    // Request during S4: yellow not aborted, S0 lasts one cycle.
    add(1'b1, 2'd1, 2'd0);
    add(1'b0, 2'd1, 2'd0);
    add(1'b0, 2'd1, 2'd0);
    add(1'b0, 2'd0, 2'd0);
    add(1'b0, 2'd0, 2'd0);
    add(1'b0, 2'd0, 2'd2);
    add(1'b0, 2'd0, 2'd1);
    add(1'b1, 2'd0, 2'd1);
    add(1'b1, 2'd0, 2'd1);
    add(1'b1, 2'd2, 2'd0);
    add(1'b1, 2'd1, 2'd0);
    add(1'b0, 2'd1, 2'd0);
    add(1'b0, 2'd1, 2'd0);
    add(1'b0, 2'd0, 2'd0);
    add(1'b0, 2'd0, 2'd0);
    add(1'b0, 2'd0, 2'd2);
    for (int i = 0; i < 3; i++) add(1'b0, 2'd0, 2'd1);
    add(1'b0, 2'd2, 2'd0);

    // Reset behaviour.
    #7;
    check("reset_during", 2'd2, 2'd0);
    #10;
    clear = 1'b0;
    step(1'b0);
    check("reset_after", 2'd2, 2'd0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      check("idle_s0", 2'd2, 2'd0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].x);
      check($sformatf("vec%0d", i), vecs[i].h, vecs[i].c);
    end

    // Held request keeps country road green.
    for (int i = 0; i < 5; i++) step(1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      check("held_s3", 2'd0, 2'd2);
    end

    // Asynchronous clear from S3, then from S2.
    #2;
    clear = 1'b1;
    #1;
    check("clear_s3_async", 2'd2, 2'd0);
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1);
    check("pre_clear_s2", 2'd0, 2'd0);
    #2;
    clear = 1'b1;
    #1;
    check("clear_s2_async", 2'd2, 2'd0);
    @(negedge clock);
    clear = 1'b0;
    step(1'b0);
    check("post_clear_idle", 2'd2, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("post_clear_yellow", 2'd1, 2'd0);
    end
    step(1'b0);
    check("post_clear_red", 2'd0, 2'd0);

    // Safety under pulsed and random sensor activity.
    for (int i = 0; i < 500; i++) begin
      if ((i % 65) >= 50) step(1'b1);
      else step($urandom_range(0, 7) == 0);
      checks++;
      if ((hwy != 2'd0 && cntry != 2'd0) || hwy == 2'd3 || cntry == 2'd3) begin
        errors++;
        $display("FAIL safety t=%0t: hwy=%0d cntry=%0d, expected one road RED and no code 3",
                 $time, hwy, cntry);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_control.md
# sig_control

Traffic-signal controller for a highway/country-road crossing. The highway stays green by default. A car sensor on the country road requests green for the country road, and the block sequences both lights through yellow and all-red phases. It is a single-clock Moore state machine that drives two 2-bit light codes to the lamp drivers.

## Interface
Parameters:
- Y2RDELAY, default 3: number of clock cycles a yellow phase lasts (states S1 and S4). Legal range ≥1.
- R2GDELAY, default 2: number of clock cycles the all-red phase lasts (state S2). Legal range ≥1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset; one clock, asynchronous, active-high.
- X  in  1  country-road car sensor; 1 = car waiting. Sampled on the rising edge.
- hwy  out  2  highway light code.
- cntry  out  2  country-road light code.

Light codes: RED=2'd0, YELLOW=2'd1, GREEN=2'd2. Code 2'd3 is never driven.

## Operation
The state register is one of five states. Outputs are a pure decode of state:
- S0: hwy=GREEN, cntry=RED.
- S1: hwy=YELLOW, cntry=RED.
- S2: hwy=RED, cntry=RED.
- S3: hwy=RED, cntry=GREEN.
- S4: hwy=RED, cntry=YELLOW.

Transitions, evaluated on each rising edge:
- S0 → S1 when X=1; otherwise stay in S0.
- S1 → S2 after exactly Y2RDELAY cycles in S1.
- S2 → S3 after exactly R2GDELAY cycles in S2.
- S3 → S4 when X=0; otherwise stay in S3.
- S4 → S0 after exactly Y2RDELAY cycles in S4.

Phase timer:
- A down-counter is loaded with (delay−1) on entry to S1, S2 or S4.
- The state advances on the edge where the counter is 0.
- Counter width is $clog2(max(Y2RDELAY,R2GDELAY)).
- The counter has no effect in S0 or S3.

Boundary rules:
- X is ignored in S1, S2 and S4. A request cannot abort a yellow or all-red phase.
- If X=0 on entry to S3, S3 lasts exactly one cycle (cntry GREEN for one cycle), then S4.
- If X=1 while in S4, the block still returns to S0. It then leaves S0 on the next edge, so S0 lasts one cycle.
- Both roads are never simultaneously non-RED.
- When clear asserts mid-sequence, the block drops immediately to S0 and the timer is cleared.

## Timing
- Reset values: state=S0, timer=0, hwy=2'd2 (GREEN), cntry=2'd0 (RED). Outputs change asynchronously on clear assertion.
- After clear deasserts, the first rising edge evaluates normally.
- Latency from X=1 sampled in S0 to cntry=GREEN: 1 + Y2RDELAY + R2GDELAY edges. With default delays this is 6 edges.
- Latency from X=0 sampled in S3 to hwy=GREEN: 1 + Y2RDELAY edges. With default delays this is 4 edges.
- Outputs are registered-state decodes, glitch-free, valid after clock-to-q plus decode delay.

## Structure
- Shared package sig_control_pkg holds:
  - the state enum (S0..S4);
  - the light-code constants RED/YELLOW/GREEN;
  - the default delay values.
- One sub-module is natural: sig_timer, a loadable down-counter with a zero flag. It is instantiated once and shared by S1, S2 and S4.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset: hold clear=1 for 17 ns with a 10 ns clock, X=0 → hwy=2, cntry=0 both during and after reset. State stays in S0 for 50 cycles.
- Full cycle: X=1 for 15 cycles, then 0 → sequence per edge is:
  - hwy=1 for 3 cycles;
  - hwy=0/cntry=0 for 2 cycles;
  - cntry=2 until the edge after X falls;
  - cntry=1 for 3 cycles;
  - back to hwy=2/cntry=0.
- Short request: X=1 for one cycle only → the full sequence still runs. S3 lasts exactly one cycle, then S4, then S0.
- Held request: X stuck at 1 → the block stays in S3 indefinitely, with cntry=2 and hwy=0.
- Mid-sequence reset: assert clear during S2 → hwy=2 and cntry=0 immediately, without waiting for a clock edge. After release, a new X request sees a full 3-cycle yellow.
- Safety: run random X for 5000 ns across repeating 500 ns low / 150 ns high pulses → never both hwy≠0 and cntry≠0, and code 3 never appears.
